// File: rtl/regfile_rd_pkg.sv
// Shared definitions for the register-file read responder.
//   RSP_DEPTH   : response buffer depth
//   RSP_PTR_W   : buffer pointer width
//   RSP_CNT_W   : buffer occupancy counter width (holds 0..RSP_DEPTH)
//   rsp_entry_t : canonical {data, err} response layout at the default register width
//   ptr_inc     : wrapping pointer increment
package regfile_rd_pkg;

  localparam int unsigned RSP_DEPTH  = 2;
  localparam int unsigned RSP_PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned RSP_CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned RSP_DATA_W = 32;

  // The top builds the same layout with its own DATA_WIDTH; err is the LSB.
  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic                  err;
  } rsp_entry_t;

  function automatic logic [RSP_PTR_W-1:0] ptr_inc(input logic [RSP_PTR_W-1:0] ptr);
    return (ptr == RSP_PTR_W'(RSP_DEPTH - 1)) ? '0 : ptr + RSP_PTR_W'(1);
  endfunction

endpackage

// File: rtl/regfile_rd_if.sv
// Read request/response handshake between the bus adapter and the read responder.
//   master : bus adapter side (drives requests, consumes responses)
//   slave  : regfile_rd_port side
//   rd_req_vld/rd_req_rdy/rd_addr           : word-addressed read request
//   rd_rsp_vld/rd_rsp_rdy/rd_rsp_data/_err  : read response
interface regfile_rd_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 8
);

  logic                  rd_req_vld;
  logic                  rd_req_rdy;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_rsp_vld;
  logic                  rd_rsp_rdy;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  rd_rsp_err;

  modport master (
    output rd_req_vld, rd_addr, rd_rsp_rdy,
    input  rd_req_rdy, rd_rsp_vld, rd_rsp_data, rd_rsp_err
  );

  modport slave (
    input  rd_req_vld, rd_addr, rd_rsp_rdy,
    output rd_req_rdy, rd_rsp_vld, rd_rsp_data, rd_rsp_err
  );

endinterface

// File: rtl/regfile_rd_skid.sv
// Response buffer for the read responder: small FIFO of RSP_DEPTH entries.
//   clk, rst_n : clock, asynchronous active-low reset (clears entries, pointers, count)
//   push       : write push_data (ignored when full)
//   push_data  : entry to enqueue
//   pop        : drop head entry (ignored when empty)
//   pop_data   : head entry
//   full/empty : occupancy flags, from registered count only
module regfile_rd_skid
  import regfile_rd_pkg::*;
#(
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0]     mem_q [RSP_DEPTH];
  logic [RSP_PTR_W-1:0] wr_ptr_q;
  logic [RSP_PTR_W-1:0] rd_ptr_q;
  logic [RSP_CNT_W-1:0] count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count_q == RSP_CNT_W'(RSP_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is presented straight from storage; reset clears it so the data output reads 0.
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + RSP_CNT_W'(1);
        2'b01:   count_q <= count_q - RSP_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_rd_port.sv
// Read-side responder for the generated register file. Accepts word-addressed reads, snapshots
// the addressed register into a 2-entry response buffer and pulses a one-hot read strobe for
// clear-on-read logic one cycle after acceptance.
//   clk, rst_n : clock, asynchronous active-low reset
//   reg_q      : flattened register values, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_strobe  : one-hot read pulse, registered
//   bus        : regfile_rd_if slave (request and response handshakes)
// Optional macro REGFILE_RD_ERR_EN: unmapped reads return rd_rsp_err=1; otherwise rd_rsp_err is
// tied low and the err bit is not stored.
module regfile_rd_port
  import regfile_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            rd_strobe,
  regfile_rd_if.slave                    bus
);

`ifdef REGFILE_RD_ERR_EN
  localparam int unsigned EntryW = DATA_WIDTH + 1;
`else
  localparam int unsigned EntryW = DATA_WIDTH;
`endif

  logic                  rdy_en_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   sel_onehot;
  logic [NUM_REGS-1:0]   strobe_q;
  logic [EntryW-1:0]     push_data;
  logic [EntryW-1:0]     head;
  logic                  buf_full;
  logic                  buf_empty;

  // Holds off requests during reset and for the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // Registered state only: no path from rd_rsp_rdy.
  assign bus.rd_req_rdy = rdy_en_q & ~buf_full;
  assign accept         = bus.rd_req_vld & bus.rd_req_rdy;

  // An unmapped address matches no index, so data and strobe both fall out as zero.
  always_comb begin
    sel_data   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr == ADDR_W'(i)) begin
        sel_data      = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef REGFILE_RD_ERR_EN
  logic mapped;
  assign mapped    = (32'(bus.rd_addr) < NUM_REGS);
  assign push_data = {sel_data, ~mapped};
`else
  assign push_data = sel_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= accept ? sel_onehot : '0;
    end
  end

  assign rd_strobe = strobe_q;

  regfile_rd_skid #(
    .Width (EntryW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_data),
    .pop       (bus.rd_rsp_rdy),
    .pop_data  (head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign bus.rd_rsp_vld  = ~buf_empty;
  assign bus.rd_rsp_data = head[EntryW-1 -: DATA_WIDTH];
`ifdef REGFILE_RD_ERR_EN
  assign bus.rd_rsp_err  = head[0];
`else
  assign bus.rd_rsp_err  = 1'b0;
`endif

endmodule
